// File: rtl/amstrad_mem_arbiter_if.sv
// Bundle of the arbiter's requester ports (video, CPU, DMA) and its RAM backend port.
// The slave modport is the arbiter; the master modport is its environment.
interface amstrad_mem_arbiter_if;
   logic        vid_req;
   logic [22:0] vid_addr;
   logic [15:0] vid_data;
   logic        vid_valid;
   logic        vid_overrun;

   logic        cpu_rd;
   logic        cpu_wr;
   logic [22:0] cpu_addr;
   logic [7:0]  cpu_dout;
   logic [7:0]  cpu_din;
   logic        cpu_wait;

   logic        dma_req;
   logic        dma_we;
   logic [22:0] dma_addr;
   logic [7:0]  dma_dout;
   logic [7:0]  dma_din;
   logic        dma_ack;

   logic        ram_req;
   logic        ram_we;
   logic [22:0] ram_addr;
   logic [7:0]  ram_dout;
   logic [15:0] ram_din;
   logic        ram_ack;

   modport slave (
      input  vid_req, vid_addr, cpu_rd, cpu_wr, cpu_addr, cpu_dout,
             dma_req, dma_we, dma_addr, dma_dout, ram_din, ram_ack,
      output vid_data, vid_valid, vid_overrun, cpu_din, cpu_wait,
             dma_din, dma_ack, ram_req, ram_we, ram_addr, ram_dout
   );

   modport master (
      output vid_req, vid_addr, cpu_rd, cpu_wr, cpu_addr, cpu_dout,
             dma_req, dma_we, dma_addr, dma_dout, ram_din, ram_ack,
      input  vid_data, vid_valid, vid_overrun, cpu_din, cpu_wait,
             dma_din, dma_ack, ram_req, ram_we, ram_addr, ram_dout
   );
endinterface

// File: rtl/amstrad_mem_arbiter.sv
// Amstrad memory arbiter: one outstanding backend transaction shared by video fetch,
// CPU byte accesses and a DMA loader, with a starvation guard that promotes DMA.
module amstrad_mem_arbiter #(
   parameter int unsigned STARVE_MAX = 15
) (
   input  logic                 clk,
   input  logic                 reset,
   amstrad_mem_arbiter_if.slave bus
);

   typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;
   typedef enum logic [1:0] {OWN_VID = 2'd0, OWN_CPU = 2'd1, OWN_DMA = 2'd2} owner_t;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   // Backend returns a 16-bit word; byte requesters take the half chosen by address bit 0.
   function automatic logic [7:0] pick_byte(input logic [15:0] word, input logic odd);
      pick_byte = odd ? word[15:8] : word[7:0];
   endfunction

   state_t      state_q;
   owner_t      owner_q;
   logic        ram_req_q;
   logic        ram_we_q;
   logic [22:0] ram_addr_q;
   logic [7:0]  ram_dout_q;
   logic        vid_pend_q;
   logic [22:0] vid_addr_q;
   logic        vid_overrun_q;
   logic [15:0] vid_data_q;
   logic        vid_valid_q;
   logic        cpu_done_q;
   logic [7:0]  cpu_din_q;
   logic [7:0]  dma_din_q;
   logic        dma_ack_q;
   logic [3:0]  starve_q;
   logic [3:0]  starve_d;

   logic        cpu_act;
   logic        vid_want;
   logic        cpu_want;
   logic        dma_want;
   logic        grant_vid;
   logic        grant_cpu;
   logic        grant_dma;
   logic [22:0] vid_grant_addr;

   // Request qualification and priority selection for the current IDLE cycle.
   always_comb begin
      cpu_act        = bus.cpu_rd | bus.cpu_wr;
      vid_want       = vid_pend_q | bus.vid_req;
      cpu_want       = cpu_act & ~cpu_done_q;
      // dma_req is still high in the cycle dma_ack is shown; do not serve it twice
      dma_want       = bus.dma_req & ~dma_ack_q;
      vid_grant_addr = bus.vid_req ? bus.vid_addr : vid_addr_q;
      grant_vid      = 1'b0;
      grant_cpu      = 1'b0;
      grant_dma      = 1'b0;
      if (state_q == IDLE) begin
         if (dma_want && (starve_q == STARVE_LIM)) begin
            grant_dma = 1'b1;
         end else if (vid_want) begin
            grant_vid = 1'b1;
         end else if (cpu_want) begin
            grant_cpu = 1'b1;
         end else if (dma_want) begin
            grant_dma = 1'b1;
         end else begin
            grant_dma = 1'b0;
         end
      end else begin
         grant_vid = 1'b0;
      end
   end

   // Starvation counter next state: counts grants that bypass a waiting DMA.
   always_comb begin
      starve_d = starve_q;
      if (grant_dma) begin
         starve_d = 4'd0;
      end else if ((grant_vid | grant_cpu) && bus.dma_req && (starve_q != STARVE_LIM)) begin
         starve_d = starve_q + 4'd1;
      end else begin
         starve_d = starve_q;
      end
   end

   // Arbitration FSM, request bookkeeping and all registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         owner_q       <= OWN_VID;
         ram_req_q     <= 1'b0;
         ram_we_q      <= 1'b0;
         ram_addr_q    <= 23'd0;
         ram_dout_q    <= 8'd0;
         vid_pend_q    <= 1'b0;
         vid_addr_q    <= 23'd0;
         vid_overrun_q <= 1'b0;
         vid_data_q    <= 16'd0;
         vid_valid_q   <= 1'b0;
         cpu_done_q    <= 1'b0;
         cpu_din_q     <= 8'd0;
         dma_din_q     <= 8'd0;
         dma_ack_q     <= 1'b0;
         starve_q      <= 4'd0;
      end else begin
         vid_valid_q <= 1'b0;
         dma_ack_q   <= 1'b0;
         starve_q    <= starve_d;

         // A granted video request is consumed; a later one waits again (latest address wins).
         if (grant_vid) begin
            vid_pend_q <= 1'b0;
         end else if (bus.vid_req) begin
            vid_pend_q <= 1'b1;
            vid_addr_q <= bus.vid_addr;
         end else begin
            vid_pend_q <= vid_pend_q;
         end
         if (bus.vid_req && vid_pend_q) begin
            vid_overrun_q <= 1'b1;
         end else begin
            vid_overrun_q <= vid_overrun_q;
         end

         if (!cpu_act) begin
            cpu_done_q <= 1'b0;
         end else begin
            cpu_done_q <= cpu_done_q;
         end

         case (state_q)
            IDLE: begin
               if (grant_vid) begin
                  owner_q    <= OWN_VID;
                  ram_addr_q <= vid_grant_addr;
                  ram_we_q   <= 1'b0;
                  ram_dout_q <= 8'd0;
                  ram_req_q  <= 1'b1;
                  state_q    <= BUSY;
               end else if (grant_cpu) begin
                  owner_q    <= OWN_CPU;
                  ram_addr_q <= bus.cpu_addr;
                  ram_we_q   <= bus.cpu_wr;
                  ram_dout_q <= bus.cpu_dout;
                  ram_req_q  <= 1'b1;
                  state_q    <= BUSY;
               end else if (grant_dma) begin
                  owner_q    <= OWN_DMA;
                  ram_addr_q <= bus.dma_addr;
                  ram_we_q   <= bus.dma_we;
                  ram_dout_q <= bus.dma_dout;
                  ram_req_q  <= 1'b1;
                  state_q    <= BUSY;
               end else begin
                  ram_req_q  <= 1'b0;
                  state_q    <= IDLE;
               end
            end
            BUSY: begin
               if (bus.ram_ack) begin
                  ram_req_q <= 1'b0;
                  state_q   <= IDLE;
                  case (owner_q)
                     OWN_VID: begin
                        vid_data_q  <= bus.ram_din;
                        vid_valid_q <= 1'b1;
                     end
                     OWN_CPU: begin
                        cpu_done_q <= 1'b1;
                        if (!ram_we_q) begin
                           cpu_din_q <= pick_byte(bus.ram_din, ram_addr_q[0]);
                        end else begin
                           cpu_din_q <= cpu_din_q;
                        end
                     end
                     OWN_DMA: begin
                        dma_ack_q <= 1'b1;
                        if (!ram_we_q) begin
                           dma_din_q <= pick_byte(bus.ram_din, ram_addr_q[0]);
                        end else begin
                           dma_din_q <= dma_din_q;
                        end
                     end
                     default: begin
                        ram_req_q <= 1'b0;
                     end
                  endcase
               end else begin
                  state_q <= BUSY;
               end
            end
            default: begin
               state_q   <= IDLE;
               ram_req_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ram_req     = ram_req_q;
   assign bus.ram_we      = ram_we_q;
   assign bus.ram_addr    = ram_addr_q;
   assign bus.ram_dout    = ram_dout_q;
   assign bus.vid_data    = vid_data_q;
   assign bus.vid_valid   = vid_valid_q;
   assign bus.vid_overrun = vid_overrun_q;
   assign bus.cpu_din     = cpu_din_q;
   assign bus.dma_din     = dma_din_q;
   assign bus.dma_ack     = dma_ack_q;
   // The CPU stall must drop in the same cycle its strobe is withdrawn or satisfied.
   assign bus.cpu_wait    = cpu_act & ~cpu_done_q;

endmodule

// File: doc/amstrad_mem_arbiter.md
AMSTRAD_MEM_ARBITER -- requirements
Module: amstrad_mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 15, sets how many grants may pass a pending DMA request before DMA is forced to top priority (range 1..15).
REQ-002 clk  in  1  system clock; all state advances on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 vid_req  in  1  one-cycle pulse: video fetch request.
REQ-005 vid_addr  in  23  video word address, sampled with vid_req.
REQ-006 vid_data  out  16  fetched video word.
REQ-007 vid_valid  out  1  one-cycle pulse: vid_data updated.
REQ-008 vid_overrun  out  1  sticky flag: vid_req arrived while a video fetch was still pending.
REQ-009 cpu_rd / cpu_wr  in  1 each  CPU memory strobes (level), at most one high.
REQ-010 cpu_addr  in  23  CPU byte address; cpu_dout  in  8  CPU write data.
REQ-011 cpu_din  out  8  CPU read data; cpu_wait  out  1  stall to CPU.
REQ-012 dma_req  in  1  level DMA (loader) request, held until dma_ack; dma_we  in  1  write when high.
REQ-013 dma_addr  in  23; dma_dout  in  8; dma_din  out  8; dma_ack  out  1  one-cycle completion pulse.
REQ-014 ram_req  out  1; ram_we  out  1; ram_addr  out  23; ram_dout  out  8: backend request, held stable until ram_ack.
REQ-015 ram_din  in  16  backend read word; ram_ack  in  1  one-cycle completion pulse.

Function
REQ-016 The FSM SHALL have two states, IDLE and BUSY, with exactly one backend transaction outstanding at a time.
REQ-017 vid_req SHALL set vid_pend and latch vid_addr; vid_req while vid_pend=1 SHALL overwrite the address (latest wins) and set vid_overrun.
REQ-018 A CPU request SHALL exist while (cpu_rd|cpu_wr)=1, cpu_done=0 and the CPU is not in service; cpu_done SHALL set on the CPU's ram_ack and clear when cpu_rd and cpu_wr are both low.
REQ-019 cpu_wait SHALL equal (cpu_rd|cpu_wr) & ~cpu_done, combinationally.
REQ-020 In IDLE, with any request present, the block SHALL grant in priority video > CPU > DMA, except that DMA goes first when starve_cnt = STARVE_MAX.
REQ-021 The grant cycle N SHALL load ram_addr/ram_we/ram_dout from the winner, and from N+1 assert ram_req in state BUSY; no request present means stay in IDLE with ram_req=0.
REQ-022 Video grants SHALL use ram_we=0; CPU grants SHALL use ram_we=cpu_wr; DMA grants SHALL use ram_we=dma_we.
REQ-023 A vid_req arriving during the video's own BUSY SHALL set vid_pend again, without overrun.
REQ-024 In BUSY, ram_ack SHALL deassert ram_req in the next cycle and return the FSM to IDLE; a new grant is possible in the cycle after return.
REQ-025 On ack: video: vid_data<=ram_din, vid_valid=1 next cycle, vid_pend cleared unless re-requested; CPU/DMA read: byte = ram_din[15:8] if addr[0]=1 else ram_din[7:0], into cpu_din/dma_din; DMA: dma_ack=1 next cycle.
REQ-026 starve_cnt (4 bits) SHALL increment, saturating at STARVE_MAX, on each non-DMA grant made while dma_req=1, and clear on a DMA grant.
REQ-027 ram_ack while IDLE SHALL be ignored.
REQ-028 Data outputs SHALL hold their last value between updates.

Reset
REQ-029 While reset=1, with no clock needed: FSM=IDLE; ram_req, ram_we, vid_valid, dma_ack, vid_overrun, vid_pend, cpu_done, starve_cnt = 0; ram_addr, ram_dout, vid_data, cpu_din, dma_din = 0.
REQ-030 Reset mid-transaction SHALL drop ram_req immediately; a late ram_ack after reset release SHALL be ignored per REQ-027.

Verification
REQ-031 CPU read, cpu_addr=0x000101, ram_din=0xA55A acked 3 cycles after ram_req -> cpu_wait high until the cycle after ack, cpu_din=0xA5, ram_we=0.
REQ-032 vid_req and cpu_wr in the same cycle -> video granted first (ram_we=0), CPU granted in the cycle after video ack returns to IDLE, cpu_wait low only after the CPU ack.
REQ-033 dma_req held, video and CPU continuously requesting, STARVE_MAX=3 -> DMA granted after exactly 3 other grants, dma_ack pulses once, starve_cnt=0.
REQ-034 Two vid_req pulses before the first grant (addr 0x10 then 0x20) -> one fetch at 0x20, vid_overrun=1 until reset.
REQ-035 Reset asserted while BUSY, ram_ack given 2 cycles after release -> ram_req=0 immediately, ack ignored, no vid_valid/dma_ack pulse.
